pipe_shifter: RTL



---
 rtl/pipe_shifter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pipe_shifter.sv
// pipe_shifter: pipelined barrel shifter (SLL/SRL/SRA/ROL) with one log-shift stage per register.
// Define PIPE_SHIFTER_FLAGS_EN to add the registered out_zero/out_carry result flags.
module pipe_shifter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
`ifdef PIPE_SHIFTER_FLAGS_EN
    output logic               out_zero,
    output logic               out_carry,
`endif
    output logic [TAG_W-1:0]   out_tag
);
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input logic [1:0] op,
                                              input logic sgn, input int s);
        logic [WIDTH-1:0] fill;
        fill = sgn ? ~({WIDTH{1'b1}} >> s) : '0;
        return op == OP_SLL ? d << s :
               op == OP_SRL ? d >> s :
               op == OP_SRA ? (d >> s) | fill :
                              (d << s) | (d >> (WIDTH - s));
    endfunction

    logic [SHAMT_W-1:0]              v_q, sv;
    logic [SHAMT_W-1:0][WIDTH-1:0]   d_q, sd, nd;
    logic [SHAMT_W-1:0][1:0]         op_q, sop;
    logic [SHAMT_W-1:0][SHAMT_W-1:0] sh_q, ssh;
    logic [SHAMT_W-1:0][TAG_W-1:0]   tag_q, stag;
    logic [SHAMT_W-1:0]              sgn_q, ssgn;
    logic                            stall;
    logic                            unused;

`ifdef PIPE_SHIFTER_FLAGS_EN
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Last bit to leave the word in this stage; later shifting stages overwrite it.
    function automatic logic carry_step(input logic [WIDTH-1:0] d, input logic r0,
                                        input logic [1:0] op, input int s);
        return op == OP_SLL ? |(d & (ONE << (WIDTH - s))) :
               op == OP_SRL || op == OP_SRA ? |(d & (ONE << (s - 1))) : r0;
    endfunction

    logic [SHAMT_W-1:0] cy_q, scy, ncy;
    logic               zero_q;
`endif

    assign stall    = v_q[SHAMT_W-1] && !out_ready;
    assign in_ready = !stall;
    assign unused   = ^{op_q[SHAMT_W-1], sh_q[SHAMT_W-1], sgn_q[SHAMT_W-1]};

    always_comb begin
        sv[0]   = in_valid;
        sd[0]   = in_data;
        sop[0]  = in_op;
        ssh[0]  = in_shamt;
        stag[0] = in_tag;
        ssgn[0] = in_data[WIDTH-1];
`ifdef PIPE_SHIFTER_FLAGS_EN
        scy[0]  = 1'b0;
`endif
        for (int k = 1; k < SHAMT_W; k++) begin
            sv[k]   = v_q[k-1];
            sd[k]   = d_q[k-1];
            sop[k]  = op_q[k-1];
            ssh[k]  = sh_q[k-1];
            stag[k] = tag_q[k-1];
            ssgn[k] = sgn_q[k-1];
`ifdef PIPE_SHIFTER_FLAGS_EN
            scy[k]  = cy_q[k-1];
`endif
        end
        for (int k = 0; k < SHAMT_W; k++) begin
            nd[k]  = ssh[k][k] ? step(sd[k], sop[k], ssgn[k], 1 << k) : sd[k];
`ifdef PIPE_SHIFTER_FLAGS_EN
            ncy[k] = ssh[k][k] ? carry_step(sd[k], nd[k][0], sop[k], 1 << k) : scy[k];
`endif
        end
    end

    // A stall freezes every stage; bubbles travel with the pipe rather than collapsing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v_q    <= '0;
            d_q    <= '0;
            op_q   <= '0;
            sh_q   <= '0;
            tag_q  <= '0;
            sgn_q  <= '0;
`ifdef PIPE_SHIFTER_FLAGS_EN
            cy_q   <= '0;
            zero_q <= 1'b0;
`endif
        end else if (!stall) begin
            v_q    <= sv;
            d_q    <= nd;
            op_q   <= sop;
            sh_q   <= ssh;
            tag_q  <= stag;
            sgn_q  <= ssgn;
`ifdef PIPE_SHIFTER_FLAGS_EN
            cy_q   <= ncy;
            zero_q <= ~|nd[SHAMT_W-1];
`endif
        end
    end

    assign out_valid = v_q[SHAMT_W-1];
    assign out_data  = d_q[SHAMT_W-1];
    assign out_tag   = tag_q[SHAMT_W-1];
`ifdef PIPE_SHIFTER_FLAGS_EN
    assign out_carry = cy_q[SHAMT_W-1];
    assign out_zero  = zero_q;
`endif
endmodule
